// File: rtl/burst_ram_pkg.sv
// rtl/burst_ram_pkg.sv - command codes and FSM states of the br_* burst interface
package burst_ram_pkg;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_READ_WAIT,
    ST_READ_BURST,
    ST_WRITE_BURST
  } state_t;

endpackage

// File: rtl/burst_ram.sv
// rtl/burst_ram.sv - burst responder RAM with calibration delay and fixed read latency
module burst_ram
  import burst_ram_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH       = 4,
  parameter int RAM_BURST_DATA_BITWIDTH  = 64,
  parameter int RAM_BURST_DATA_COUNT     = 4,
  parameter int CYCLES_BEFORE_DATA_VALID = 4,
  parameter int CYCLES_BEFORE_INITIATED  = 10,
  parameter     DATA_FILE                = ""
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd,
  input  logic                                 cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] data_mask,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,
  output logic                                 rd_data_valid,
  output logic                                 busy
);

  localparam int AW    = RAM_DEPTH_BITWIDTH;
  localparam int NB    = RAM_BURST_DATA_BITWIDTH / 8;
  localparam int DEPTH = 1 << AW;
  localparam int BCW   = $clog2(RAM_BURST_DATA_COUNT) + 1;
  localparam int LCW   = $clog2(CYCLES_BEFORE_DATA_VALID) + 1;
  localparam int ICW   = $clog2(CYCLES_BEFORE_INITIATED) + 1;

  // Byte columns so each lane maps onto a byte-enabled block RAM write.
  logic [NB-1:0][7:0] mem [DEPTH];

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [BCW-1:0]  beat;
  logic [LCW-1:0]  lat;
  logic [ICW-1:0]  init_cnt;
  logic [AW-1:0]   beat_addr;

  logic            wr_en;
  logic [AW-1:0]   wr_idx;

  // Truncation to AW bits gives the wrap at the top of memory.
  assign beat_addr = addr_q + AW'(beat);

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = addr;
    if (!rst && state == ST_IDLE && cmd_en && cmd == CMD_WRITE) begin
      wr_en = 1'b1;
    end else if (!rst && state == ST_WRITE_BURST) begin
      wr_en  = 1'b1;
      wr_idx = beat_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (!data_mask[b]) mem[wr_idx][b] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_INIT;
      busy          <= 1'b1;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      addr_q        <= '0;
      beat          <= '0;
      lat           <= '0;
      init_cnt      <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt == ICW'(CYCLES_BEFORE_INITIATED - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_en) begin
            addr_q <= addr;
            beat   <= '0;
            lat    <= '0;
            if (cmd == CMD_READ) begin
              state <= ST_READ_WAIT;
              busy  <= 1'b1;
            end else if (RAM_BURST_DATA_COUNT > 1) begin
              // Beat 0 is already written this edge; the rest follow back-to-back.
              state <= ST_WRITE_BURST;
              busy  <= 1'b1;
              beat  <= BCW'(1);
            end
          end
        end
        ST_READ_WAIT: begin
          if (lat == LCW'(CYCLES_BEFORE_DATA_VALID - 1)) begin
            rd_data       <= mem[beat_addr];
            rd_data_valid <= 1'b1;
            beat          <= beat + 1'b1;
            state         <= ST_READ_BURST;
          end else begin
            lat <= lat + 1'b1;
          end
        end
        ST_READ_BURST: begin
          if (beat == BCW'(RAM_BURST_DATA_COUNT)) begin
            rd_data_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            rd_data <= mem[beat_addr];
            beat    <= beat + 1'b1;
          end
        end
        ST_WRITE_BURST: begin
          if (beat == BCW'(RAM_BURST_DATA_COUNT - 1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        default: begin
          state <= ST_INIT;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_ram.sv
// tb/tb_burst_ram.sv - directed self-checking bench for burst_ram
module tb_burst_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd;
  logic        cmd_en;
  logic [3:0]  addr;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_data_valid;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [63:0] wd [4];
  logic [7:0]  wm [4];
  logic [63:0] rb [4];
  int first_edge, nvalid, done_edge, busy_cnt, init_edges, any_valid;

  burst_ram dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
    .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
    .rd_data_valid(rd_data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_init();
    init_edges = 0;
    any_valid  = 0;
    for (int n = 1; n <= 30 && init_edges == 0; n++) begin
      tick();
      if (rd_data_valid) any_valid = 1;
      if (!busy) init_edges = n;
    end
    cmd_en = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] a);
    cmd = 1'b1; addr = a; cmd_en = 1'b1;
    wr_data = wd[0]; data_mask = wm[0];
    tick();
    cmd_en = 1'b0;
    busy_cnt  = int'(busy);
    any_valid = int'(rd_data_valid);
    for (int k = 1; k < 4; k++) begin
      wr_data = wd[k]; data_mask = wm[k];
      tick();
      busy_cnt += int'(busy);
      if (rd_data_valid) any_valid = 1;
    end
    data_mask = 8'hFF;
  endtask

  task automatic read_burst(input logic [3:0] a, input int p1, input int p2);
    cmd = 1'b0; addr = a; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0; addr = 4'd14;
    first_edge = 0; nvalid = 0; done_edge = 0;
    for (int i = 0; i < 4; i++) rb[i] = '0;
    for (int n = 1; n <= 20 && done_edge == 0; n++) begin
      cmd_en = (n == p1 || n == p2);
      tick();
      if (rd_data_valid) begin
        if (nvalid == 0) first_edge = n;
        if (nvalid < 4) rb[nvalid] = rd_data;
        nvalid++;
      end
      if (!busy) done_edge = n;
    end
    cmd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0;
    wr_data = '0; data_mask = 8'hFF;
    tick(); tick();
    check("reset_rd_data", rd_data, 64'h0);
    check("reset_valid", {63'b0, rd_data_valid}, 64'h0);
    check("reset_busy", {63'b0, busy}, 64'h1);

    // Calibration window with a read request held the whole time.
    rst = 1'b0; cmd = 1'b0; cmd_en = 1'b1; addr = 4'd0;
    wait_init();
    check("init_busy_cycles", 64'(init_edges), 64'd10);
    check("init_no_valid", 64'(any_valid), 64'd0);
    tick();
    check("init_cmd_not_taken", {63'b0, busy}, 64'h0);

    wd[0] = 64'h1111111111111111; wd[1] = 64'h2222222222222222;
    wd[2] = 64'h3333333333333333; wd[3] = 64'h4444444444444444;
    wm[0] = 8'h00; wm[1] = 8'h00; wm[2] = 8'h00; wm[3] = 8'h00;
    write_burst(4'd0);
    check("write_busy_cycles", 64'(busy_cnt), 64'd3);
    check("write_no_valid", 64'(any_valid), 64'd0);

    read_burst(4'd0, 0, 0);
    check("read_first_edge", 64'(first_edge), 64'd4);
    check("read_beats", 64'(nvalid), 64'd4);
    check("read_done_edge", 64'(done_edge), 64'd8);
    check("read_beat0", rb[0], 64'h1111111111111111);
    check("read_beat1", rb[1], 64'h2222222222222222);
    check("read_beat2", rb[2], 64'h3333333333333333);
    check("read_beat3", rb[3], 64'h4444444444444444);
    check("read_hold_last", rd_data, 64'h4444444444444444);

    wd[0] = 64'hFFFFFFFFFFFFFFFF; wd[1] = 64'hDEADDEADDEADDEAD;
    wd[2] = 64'hDEADDEADDEADDEAD; wd[3] = 64'hDEADDEADDEADDEAD;
    wm[0] = 8'h0F; wm[1] = 8'hFF; wm[2] = 8'hFF; wm[3] = 8'hFF;
    write_burst(4'd2);
    read_burst(4'd2, 0, 0);
    check("mask_beat0", rb[0], 64'hFFFFFFFF33333333);
    check("mask_beat1_untouched", rb[1], 64'h4444444444444444);

    wd[0] = 64'hA0A0A0A0A0A0A0A0; wd[1] = 64'hA1A1A1A1A1A1A1A1;
    wd[2] = 64'hA2A2A2A2A2A2A2A2; wd[3] = 64'hA3A3A3A3A3A3A3A3;
    wm[0] = 8'h00; wm[1] = 8'h00; wm[2] = 8'h00; wm[3] = 8'h00;
    write_burst(4'd14);
    read_burst(4'd14, 0, 0);
    check("wrap_beat0", rb[0], 64'hA0A0A0A0A0A0A0A0);
    check("wrap_beat1", rb[1], 64'hA1A1A1A1A1A1A1A1);
    check("wrap_beat2", rb[2], 64'hA2A2A2A2A2A2A2A2);
    check("wrap_beat3", rb[3], 64'hA3A3A3A3A3A3A3A3);

    read_burst(4'd0, 2, 6);
    check("pulse_beats", 64'(nvalid), 64'd4);
    check("pulse_done_edge", 64'(done_edge), 64'd8);
    check("pulse_beat0", rb[0], 64'hA2A2A2A2A2A2A2A2);
    check("pulse_beat1", rb[1], 64'hA3A3A3A3A3A3A3A3);
    check("pulse_beat2", rb[2], 64'hFFFFFFFF33333333);
    check("pulse_beat3", rb[3], 64'h4444444444444444);
    tick();
    check("pulse_idle_after", {63'b0, busy}, 64'h0);

    // Reset while beat 1 of a read is on the bus.
    cmd = 1'b0; addr = 4'd0; cmd_en = 1'b1;
    tick();
    cmd_en = 1'b0;
    nvalid = 0;
    for (int n = 1; n <= 20 && nvalid < 2; n++) begin
      tick();
      if (rd_data_valid) nvalid++;
    end
    check("rst_mid_reached_beat1", 64'(nvalid), 64'd2);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", {63'b0, rd_data_valid}, 64'h0);
    check("rst_mid_busy", {63'b0, busy}, 64'h1);
    check("rst_mid_rd_data", rd_data, 64'h0);
    rst = 1'b0;
    wait_init();
    check("rst_mid_init_cycles", 64'(init_edges), 64'd10);
    read_burst(4'd0, 0, 0);
    check("rst_mid_mem0", rb[0], 64'hA2A2A2A2A2A2A2A2);
    check("rst_mid_mem1", rb[1], 64'hA3A3A3A3A3A3A3A3);
    check("rst_mid_mem2", rb[2], 64'hFFFFFFFF33333333);
    check("rst_mid_mem3", rb[3], 64'h4444444444444444);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
